// File: rtl/trax_path_tracer_pkg.sv
// ---------------------------------------------------------------------------
// trax_path_tracer_pkg
// Shared definitions for the Trax path tracer:
//   - side/direction encodings (0 left, 1 up, 2 right, 3 down)
//   - tile-code constants
//   - result encodings reported on o_result
//   - FSM state type
//   - opposite(): side seen by the neighbour when the path crosses a tile edge
// ---------------------------------------------------------------------------
package trax_path_tracer_pkg;

   localparam logic [1:0] DIR_L = 2'd0;
   localparam logic [1:0] DIR_U = 2'd1;
   localparam logic [1:0] DIR_R = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   localparam logic [3:0] TILE_EMPTY     = 4'd0;
   localparam logic [3:0] TILE_MAX_VALID = 4'd6;

   localparam logic [1:0] RES_EMPTY = 2'b00;
   localparam logic [1:0] RES_LOOP  = 2'b01;
   localparam logic [1:0] RES_EDGE  = 2'b10;
   localparam logic [1:0] RES_ERROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EVAL = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Left<->right and up<->down differ only in bit 1 of the encoding.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/trax_exit_lut.sv
// ---------------------------------------------------------------------------
// trax_exit_lut
// Combinational map from (tile code, line colour, entry side) to exit side.
//   i_tile   [3:0]  tile code (0 empty, 1..6 placed, 7..15 invalid)
//   i_color         1 white line, 0 black line
//   i_entry  [1:0]  side the path enters the tile
//   o_exit   [1:0]  side the path leaves the tile (valid only with o_valid)
//   o_valid         1 when the tile is placed and the entry side carries the
//                   selected colour
// ---------------------------------------------------------------------------
module trax_exit_lut
   import trax_path_tracer_pkg::*;
(
   input  logic [3:0] i_tile,
   input  logic       i_color,
   input  logic [1:0] i_entry,
   output logic [1:0] o_exit,
   output logic       o_valid
);

   logic [1:0] w_side_a;
   logic [1:0] w_side_b;
   logic       w_placed;

   // Each placed tile joins two sides with white; black joins the other two.
   always_comb begin
      w_side_a = DIR_L;
      w_side_b = DIR_L;
      w_placed = 1'b1;
      case (i_tile)
         4'd1: begin w_side_a = i_color ? DIR_L : DIR_U; w_side_b = i_color ? DIR_D : DIR_R; end
         4'd2: begin w_side_a = i_color ? DIR_U : DIR_L; w_side_b = i_color ? DIR_R : DIR_D; end
         4'd3: begin w_side_a = i_color ? DIR_U : DIR_L; w_side_b = i_color ? DIR_D : DIR_R; end
         4'd4: begin w_side_a = i_color ? DIR_L : DIR_U; w_side_b = i_color ? DIR_R : DIR_D; end
         4'd5: begin w_side_a = i_color ? DIR_L : DIR_R; w_side_b = i_color ? DIR_U : DIR_D; end
         4'd6: begin w_side_a = i_color ? DIR_R : DIR_L; w_side_b = i_color ? DIR_D : DIR_U; end
         default: w_placed = 1'b0;
      endcase
   end

   always_comb begin
      o_exit  = DIR_L;
      o_valid = 1'b0;
      if (w_placed) begin
         if (i_entry == w_side_a) begin
            o_exit  = w_side_b;
            o_valid = 1'b1;
         end else if (i_entry == w_side_b) begin
            o_exit  = w_side_a;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trax_path_tracer.sv
// ---------------------------------------------------------------------------
// trax_path_tracer
// Follows one coloured line across a Trax board held in external memory,
// one tile per READ/EVAL pair, and reports how the line ends.
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 trace request (accepted in IDLE only)
//   i_start_row/col [3:0]   first tile
//   i_start_dir     [1:0]   side entering the first tile
//   i_color                 1 white, 0 black
//   i_abort                 cancel an active trace (READ/EVAL), no done
//   o_mem_rd, o_mem_addr    board read strobe and {row,col}
//   i_mem_rdata     [3:0]   tile code, valid the cycle after o_mem_rd
//   o_busy                  FSM not in IDLE
//   o_done                  one-cycle completion pulse
//   o_result        [1:0]   EMPTY/LOOP/EDGE/ERROR, held until next done
//   o_end_row/col/dir       final position (EDGE: exit side), held
//   o_length        [7:0]   tiles traversed, held
//   o_dbg_state     [1:0]   current FSM state
// Handshake: i_start is a single-cycle request with no ready; it is taken only
// when o_busy is low. Results are valid from the o_done cycle until the next.
// ---------------------------------------------------------------------------
module trax_path_tracer
   import trax_path_tracer_pkg::*;
#(
   parameter int BOARD_DIM = 16,
   parameter int MAX_STEPS = 255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [3:0] i_start_row,
   input  logic [3:0] i_start_col,
   input  logic [1:0] i_start_dir,
   input  logic       i_color,
   input  logic       i_abort,
   output logic       o_mem_rd,
   output logic [7:0] o_mem_addr,
   input  logic [3:0] i_mem_rdata,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_result,
   output logic [3:0] o_end_row,
   output logic [3:0] o_end_col,
   output logic [1:0] o_end_dir,
   output logic [7:0] o_length,
   output logic [1:0] o_dbg_state
);

   localparam logic [3:0] LAST_IDX   = 4'(BOARD_DIM - 1);
   localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

   state_t     r_state;
   logic [3:0] r_st_row, r_st_col, r_cur_row, r_cur_col;
   logic [1:0] r_st_dir, r_cur_dir;
   logic       r_color;
   logic [7:0] r_steps;
   logic       r_mem_rd, r_busy, r_done;
   logic [1:0] r_result, r_end_dir;
   logic [3:0] r_end_row, r_end_col;
   logic [7:0] r_length;

   logic [1:0] w_exit;
   logic       w_lut_valid;
   logic       w_off_board;
   logic [3:0] w_nxt_row, w_nxt_col;
   logic [1:0] w_nxt_dir;
   logic [7:0] w_steps_inc;
   logic       w_finish;
   logic [1:0] w_fin_res, w_fin_dir;
   logic [3:0] w_fin_row, w_fin_col;
   logic [7:0] w_fin_len;

   trax_exit_lut u_exit_lut (
      .i_tile  (i_mem_rdata),
      .i_color (r_color),
      .i_entry (r_cur_dir),
      .o_exit  (w_exit),
      .o_valid (w_lut_valid)
   );

   // Saturating so the count can never pass the visit limit.
   assign w_steps_inc = (r_steps == STEP_LIMIT) ? r_steps : r_steps + 8'd1;
   assign w_nxt_dir   = opposite(w_exit);

   always_comb begin
      w_off_board = 1'b0;
      w_nxt_row   = r_cur_row;
      w_nxt_col   = r_cur_col;
      case (w_exit)
         DIR_L: begin w_off_board = (r_cur_col == 4'd0);     w_nxt_col = r_cur_col - 4'd1; end
         DIR_U: begin w_off_board = (r_cur_row == 4'd0);     w_nxt_row = r_cur_row - 4'd1; end
         DIR_R: begin w_off_board = (r_cur_col == LAST_IDX); w_nxt_col = r_cur_col + 4'd1; end
         default: begin w_off_board = (r_cur_row == LAST_IDX); w_nxt_row = r_cur_row + 4'd1; end
      endcase
   end

   // Outcome of evaluating the tile now on i_mem_rdata; used only in EVAL.
   always_comb begin
      w_finish  = 1'b0;
      w_fin_res = RES_EMPTY;
      w_fin_row = r_cur_row;
      w_fin_col = r_cur_col;
      w_fin_dir = r_cur_dir;
      w_fin_len = r_steps;
      if (i_mem_rdata == TILE_EMPTY) begin
         w_finish = 1'b1;
      end else if (!w_lut_valid) begin
         w_finish  = 1'b1;
         w_fin_res = RES_ERROR;
      end else if (w_off_board) begin
         w_finish  = 1'b1;
         w_fin_res = RES_EDGE;
         w_fin_dir = w_exit;
         w_fin_len = w_steps_inc;
      end else if (w_nxt_row == r_st_row && w_nxt_col == r_st_col && w_nxt_dir == r_st_dir) begin
         w_finish  = 1'b1;
         w_fin_res = RES_LOOP;
         w_fin_row = w_nxt_row;
         w_fin_col = w_nxt_col;
         w_fin_dir = w_nxt_dir;
         w_fin_len = w_steps_inc;
      end else if (w_steps_inc == STEP_LIMIT) begin
         w_finish  = 1'b1;
         w_fin_res = RES_ERROR;
         w_fin_row = w_nxt_row;
         w_fin_col = w_nxt_col;
         w_fin_dir = w_nxt_dir;
         w_fin_len = w_steps_inc;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_st_row  <= 4'd0;
         r_st_col  <= 4'd0;
         r_st_dir  <= 2'd0;
         r_cur_row <= 4'd0;
         r_cur_col <= 4'd0;
         r_cur_dir <= 2'd0;
         r_color   <= 1'b0;
         r_steps   <= 8'd0;
         r_mem_rd  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= RES_EMPTY;
         r_end_row <= 4'd0;
         r_end_col <= 4'd0;
         r_end_dir <= 2'd0;
         r_length  <= 8'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_st_row  <= i_start_row;
                  r_st_col  <= i_start_col;
                  r_st_dir  <= i_start_dir;
                  r_cur_row <= i_start_row;
                  r_cur_col <= i_start_col;
                  r_cur_dir <= i_start_dir;
                  r_color   <= i_color;
                  r_steps   <= 8'd0;
                  r_mem_rd  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ST_READ;
               end
            end
            ST_READ: begin
               r_mem_rd <= 1'b0;
               if (i_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (i_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_finish) begin
                  // Results land together with the done pulse.
                  r_done    <= 1'b1;
                  r_result  <= w_fin_res;
                  r_end_row <= w_fin_row;
                  r_end_col <= w_fin_col;
                  r_end_dir <= w_fin_dir;
                  r_length  <= w_fin_len;
                  r_state   <= ST_FIN;
               end else begin
                  r_cur_row <= w_nxt_row;
                  r_cur_col <= w_nxt_col;
                  r_cur_dir <= w_nxt_dir;
                  r_steps   <= w_steps_inc;
                  r_mem_rd  <= 1'b1;
                  r_state   <= ST_READ;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_mem_rd    = r_mem_rd;
   assign o_mem_addr  = {r_cur_row, r_cur_col};
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_result    = r_result;
   assign o_end_row   = r_end_row;
   assign o_end_col   = r_end_col;
   assign o_end_dir   = r_end_dir;
   assign o_length    = r_length;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trax_path_tracer.sv
// ---------------------------------------------------------------------------
// tb_trax_path_tracer
// Directed bench for trax_path_tracer with a behavioural board memory.
// ---------------------------------------------------------------------------
module tb_trax_path_tracer;
   import trax_path_tracer_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, color, abort;
   logic [3:0] start_row, start_col;
   logic [1:0] start_dir;
   logic       mem_rd;
   logic [7:0] mem_addr;
   logic [3:0] mem_rdata = 4'd0;
   logic       busy, done;
   logic [1:0] result, end_dir, dbg_state;
   logic [3:0] end_row, end_col;
   logic [7:0] length;

   logic [3:0] board [256];
   int n_checks = 0;
   int n_errors = 0;
   int lat;

   trax_path_tracer dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_start_row(start_row), .i_start_col(start_col), .i_start_dir(start_dir),
      .i_color(color), .i_abort(abort),
      .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
      .o_busy(busy), .o_done(done), .o_result(result),
      .o_end_row(end_row), .o_end_col(end_col), .o_end_dir(end_dir),
      .o_length(length), .o_dbg_state(dbg_state)
   );

   // clock / board memory
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_rd) mem_rdata <= board[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [3:0] code);
      for (int i = 0; i < 256; i++) board[i] = code;
   endtask

   task automatic put(input int r, input int c, input logic [3:0] code);
      board[r*16 + c] = code;
   endtask

   // Called at a negedge; returns cycles from the start cycle to done.
   task automatic do_trace(input logic [3:0] r, input logic [3:0] c, input logic [1:0] d,
                           input logic col, input int poke_at, output int lt);
      start = 1'b1; start_row = r; start_col = c; start_dir = d; color = col;
      @(posedge clk); lt = 1;
      @(negedge clk); start = 1'b0;
      chk("first_rd", 32'(mem_rd), 1);
      chk("first_addr", 32'(mem_addr), 32'({r, c}));
      while (done !== 1'b1 && lt < 2000) begin
         if (lt == poke_at) begin
            start = 1'b1; start_row = ~r; start_col = ~c; start_dir = ~d; color = ~col;
         end
         @(posedge clk); lt++;
         @(negedge clk);
         start = 1'b0; start_row = r; start_col = c; start_dir = d; color = col;
      end
      chk("done_seen", 32'(done), 1);
      chk("busy_in_fin", 32'(busy), 1);
   endtask

   task automatic expect_res(input string tag, input int lt, input int exp_lat,
                             input logic [1:0] res, input logic [3:0] er, input logic [3:0] ec,
                             input logic [1:0] ed, input logic [7:0] len);
      chk({tag, "_latency"}, 32'(lt), 32'(exp_lat));
      chk({tag, "_result"}, 32'(result), 32'(res));
      chk({tag, "_end_row"}, 32'(end_row), 32'(er));
      chk({tag, "_end_col"}, 32'(end_col), 32'(ec));
      chk({tag, "_end_dir"}, 32'(end_dir), 32'(ed));
      chk({tag, "_length"}, 32'(length), 32'(len));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 0);
      chk({tag, "_busy_idle"}, 32'(busy), 0);
   endtask

   initial begin
      logic seen_done;
      rst = 1'b1; start = 1'b0; abort = 1'b0; color = 1'b1;
      start_row = 4'd0; start_col = 4'd0; start_dir = 2'd0;
      fill(4'd0);

      // reset state
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_mem_rd", 32'(mem_rd), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_length", 32'(length), 0);
      chk("rst_state", 32'(dbg_state), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // full row of straight tiles, with an ignored start mid-trace
      fill(4'd4);
      do_trace(4'd5, 4'd0, DIR_L, 1'b1, 6, lat);
      expect_res("row_edge", lat, 33, RES_EDGE, 4'd5, 4'd15, DIR_R, 8'd16);

      // abort during the third READ, then restart immediately
      start = 1'b1; start_row = 4'd5; start_col = 4'd0; start_dir = DIR_L; color = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      repeat (4) begin @(posedge clk); @(negedge clk); end
      chk("abort_in_read", 32'(mem_rd), 1);
      abort = 1'b1;
      @(posedge clk); @(negedge clk); abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_held_result", 32'(result), 32'(RES_EDGE));
      chk("abort_held_length", 32'(length), 16);
      do_trace(4'd5, 4'd0, DIR_L, 1'b1, -1, lat);
      expect_res("after_abort", lat, 33, RES_EDGE, 4'd5, 4'd15, DIR_R, 8'd16);

      // reset asserted between edges while in EVAL
      start = 1'b1; start_row = 4'd5; start_col = 4'd0; start_dir = DIR_L;
      @(posedge clk); @(negedge clk); start = 1'b0;
      @(posedge clk); #2;
      chk("pre_rst_eval", 32'(dbg_state), 32'(ST_EVAL));
      rst = 1'b1; #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_result", 32'(result), 0);
      chk("mid_rst_length", 32'(length), 0);
      chk("mid_rst_end", 32'({end_row, end_col, end_dir}), 0);
      chk("mid_rst_state", 32'(dbg_state), 0);
      @(negedge clk); rst = 1'b0;
      seen_done = 1'b0;
      repeat (4) begin @(negedge clk); if (done) seen_done = 1'b1; end
      chk("rst_no_done", 32'(seen_done), 0);
      do_trace(4'd5, 4'd0, DIR_L, 1'b1, -1, lat);
      expect_res("after_rst", lat, 33, RES_EDGE, 4'd5, 4'd15, DIR_R, 8'd16);

      // 2x2 white loop plus assorted single tiles
      fill(4'd0);
      put(0, 0, 4'd6); put(0, 1, 4'd1); put(1, 1, 4'd5); put(1, 0, 4'd2);
      put(7, 7, 4'd3); put(8, 2, 4'd9); put(0, 4, 4'd4);
      put(11, 0, 4'd2); put(10, 0, 4'd1);
      do_trace(4'd0, 4'd0, DIR_D, 1'b1, -1, lat);
      expect_res("loop", lat, 9, RES_LOOP, 4'd0, 4'd0, DIR_D, 8'd4);
      do_trace(4'd3, 4'd3, DIR_L, 1'b1, -1, lat);
      expect_res("empty", lat, 3, RES_EMPTY, 4'd3, 4'd3, DIR_L, 8'd0);
      do_trace(4'd7, 4'd7, DIR_U, 1'b0, -1, lat);
      expect_res("black_bad_side", lat, 3, RES_ERROR, 4'd7, 4'd7, DIR_U, 8'd0);
      do_trace(4'd8, 4'd2, DIR_L, 1'b1, -1, lat);
      expect_res("code9", lat, 3, RES_ERROR, 4'd8, 4'd2, DIR_L, 8'd0);
      do_trace(4'd0, 4'd4, DIR_D, 1'b0, -1, lat);
      expect_res("black_top_edge", lat, 3, RES_EDGE, 4'd0, 4'd4, DIR_U, 8'd1);
      do_trace(4'd11, 4'd0, DIR_R, 1'b1, -1, lat);
      expect_res("left_edge", lat, 5, RES_EDGE, 4'd10, 4'd0, DIR_L, 8'd2);

      // serpentine covering the board: hits the visit limit
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) put(r, c, 4'd4);
         if (r % 2 == 0) begin
            put(r, 0, (r == 0) ? 4'd4 : 4'd2);
            put(r, 15, 4'd1);
         end else begin
            put(r, 15, 4'd5);
            put(r, 0, 4'd6);
         end
      end
      do_trace(4'd0, 4'd0, DIR_L, 1'b1, -1, lat);
      chk("limit_latency", 32'(lat), 511);
      chk("limit_result", 32'(result), 32'(RES_ERROR));
      chk("limit_length", 32'(length), 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
